calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Stimulus and check engine for the `calc` accumulator calculator. It drives the other end of the calc button/switch interface.
- Replays a short programmed script of (operation, operand, expected result) entries:
  - resets the accumulator via btnu;
  - for each entry, drives btnl/btnc/btnr/sw and issues a one-cycle btnd strobe;
  - samples led after a settle window and scores it against the expected value.
- Used for on-board self-test and as a reusable bench driver in place of hand-written stimulus.

Parameters:
- DEPTH, 16, number of program entries.
- ADDR_W, 4, index width; must satisfy 2**ADDR_W >= DEPTH.
- SETTLE, 2, cycles between the end of the btnd strobe and the led sample (range 1..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- prog_we  input  1  write one program entry; ignored while busy=1.
- prog_addr  input  ADDR_W  entry index for prog_we.
- prog_data  input  35  entry fields:
  - [34:32] op = {btnl,btnc,btnr};
  - [31:16] operand (sw);
  - [15:0] expected led.
- prog_len  input  ADDR_W+1  number of entries to run; sampled at start; values above DEPTH are clamped to DEPTH.
- start  input  1  one-cycle pulse that begins a run; ignored while busy=1.
- led  input  16  accumulator value returned from calc.
- btnu  output  1  accumulator reset to calc.
- btnd  output  1  apply strobe to calc.
- btnl, btnc, btnr  output  1 each  operation select to calc.
- sw  output  16  operand to calc.
- busy  output  1  high from the cycle after start until DONE is entered.
- done  output  1  one-cycle pulse on entry to DONE.
- pass_cnt, fail_cnt  output  ADDR_W+1 each  entry scores for the current/last run.
- first_fail  output  ADDR_W  index of the first mismatching entry; valid only when fail_cnt != 0.

Behaviour:
- Reset state: every output is 0 and the FSM is in IDLE.
- Program memory: a register array, DEPTH x 35, that is not reset. A write takes effect on the clk edge while prog_we=1 and busy=0.
- Operation encoding {btnl,btnc,btnr}:
  - AND = 000, OR = 001, ADD = 010, SUB = 011;
  - SLT = 100, LSL = 101, ASR = 110, XOR = 111.
- FSM states and transitions:
  - IDLE: on start, latch the clamped length into len, clear idx, pass_cnt, fail_cnt and first_fail, then go to RST.
  - RST: btnu=1 for exactly 1 cycle. Go to SETUP if len != 0, else to DONE.
  - SETUP: {btnl,btnc,btnr} and sw are driven from entry[idx]; btnd=0. Lasts 1 cycle, then go to STROBE.
  - STROBE: btnd=1 for exactly 1 cycle; op and sw are held. Go to WAIT.
  - WAIT: btnd=0; op and sw are held. A down-counter runs SETTLE cycles, then go to CHECK.
  - CHECK: sample led for 1 cycle.
    - If led == expected, pass_cnt increments.
    - Otherwise fail_cnt increments, and first_fail <= idx only if fail_cnt was 0.
    - Then idx increments. Go to SETUP if idx+1 < len, else to DONE.
  - DONE: done=1 for 1 cycle; go to IDLE. Counters and first_fail hold until the next start.
- op and sw stay stable from SETUP through CHECK, so calc sees a clean setup before btnd and a clean hold after it.
- Latency per entry: 3+SETTLE cycles.
- Total latency, start-to-done pulse: 2 + len*(3+SETTLE) cycles, counting the start cycle as cycle 0.
- busy is 1 in the states RST through DONE.
- Boundary conditions:
  - Simultaneous start and prog_we in IDLE: both take effect; the write lands before the first SETUP reads the entry.
  - start while busy: ignored, no restart.
  - prog_len > DEPTH: clamped.
  - prog_len = 0: sequence is RST, then DONE; both counters are 0.
  - Counters cannot overflow, since len <= DEPTH <= 2**ADDR_W.
  - rst asserted mid-run: immediate return to IDLE with all outputs 0, including btnd and btnu. The program memory is preserved.
- Registered outputs only; no output is combinationally derived from led.

Decomposition:
- Shared package holds:
  - the 3-bit op encoding constants (OP_AND … OP_XOR);
  - the FSM state enum;
  - the prog_data field offsets.
- One natural sub-module: calc_seq_rom, the DEPTH x 35 write-port/read-port register array.
- The FSM and scoring logic stay in calc_sequencer.

Test Plan:
- Program the 9-entry script and check pass_cnt=9, fail_cnt=0, with a done pulse exactly 2+9*(3+SETTLE) cycles after start. Entries as (op, operand, expected):
  - ADD, 354a, 354a
  - SUB, 1234, 2316
  - OR, 1001, 3317
  - AND, f0f0, 3010
  - XOR, 1fa2, 2fb2
  - ADD, 6aa2, 9a54
  - LSL, 0004, a540
  - ASR, 0001, d2a0
  - SLT, 46ff, 0001
- Same script with entry 3's expected changed to 3011, and entry 6's expected also corrupted -> fail_cnt=2, pass_cnt=7, first_fail=3.
- prog_len=0 -> exactly one btnu cycle, btnd never asserted, done pulse 2 cycles after start, counters 0.
- Waveform check on a single entry:
  - btnd is high exactly 1 cycle per entry;
  - sw and op are stable 1 cycle before btnd and SETTLE cycles after it;
  - btnu is high exactly 1 cycle, before the first SETUP.
- start pulse during a run, and a prog_we while busy -> both ignored; the run completes unchanged and memory is unchanged.
- rst asserted during WAIT of entry 4 -> all outputs 0 asynchronously. A fresh start then reruns from entry 0 with the original program and scores 9 passes.

Source files
------------

// File: rtl/calc_sequencer_pkg.sv
// calc_sequencer_pkg: op encodings, FSM states and program-entry field offsets
package calc_sequencer_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;
  localparam int ENTRY_W  = 35;
  localparam int OP_LSB   = 32;
  localparam int OPND_LSB = 16;
  localparam int EXP_LSB  = 0;
  typedef enum logic [2:0] {S_IDLE, S_RST, S_SETUP, S_STROBE, S_WAIT, S_CHECK, S_DONE} state_t;
endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: button/switch/led bus between the sequencer and calc
interface calc_sequencer_if;
  logic btnu, btnd, btnl, btnc, btnr;
  logic [15:0] sw, led;
  modport master(output btnu, btnd, btnl, btnc, btnr, sw, input led);
  modport slave(input btnu, btnd, btnl, btnc, btnr, sw, output led);
endinterface

// File: rtl/calc_seq_rom.sv
// calc_seq_rom: unreset program store with one write port and one async read port
module calc_seq_rom #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 35
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [W-1:0]      o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: replays a programmed script into calc and scores each led result
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [ENTRY_W-1:0]  prog_data,
  input  logic [ADDR_W:0]     prog_len,
  input  logic                start,
  calc_sequencer_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     pass_cnt,
  output logic [ADDR_W:0]     fail_cnt,
  output logic [ADDR_W-1:0]   first_fail
);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  state_t               r_state;
  logic [ADDR_W:0]      r_len;
  logic [ADDR_W-1:0]    r_idx;
  logic [3:0]           r_cnt;
  logic [15:0]          r_exp;
  logic [ENTRY_W-1:0]   w_rd;
  logic [ADDR_W-1:0]    w_raddr;
  logic [ADDR_W:0]      w_len;
  logic                 w_more;
  logic                 w_load;
  // CHECK looks one entry ahead so the next SETUP is loaded on the same edge
  assign w_raddr = r_state == S_CHECK ? r_idx + 1'b1 : r_idx;
  assign w_len   = prog_len > LEN_MAX ? LEN_MAX : prog_len;
  assign w_more  = ({1'b0, r_idx} + (ADDR_W+1)'(1)) < r_len;
  assign w_load  = (r_state == S_RST && r_len != '0) || (r_state == S_CHECK && w_more);
  calc_seq_rom #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(ENTRY_W)) u_rom (
    .clk     (clk),
    .i_we    (prog_we & ~busy),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_exp      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      bus.btnu   <= 1'b0;
      bus.btnd   <= 1'b0;
      bus.btnl   <= 1'b0;
      bus.btnc   <= 1'b0;
      bus.btnr   <= 1'b0;
      bus.sw     <= '0;
    end else begin
      bus.btnu <= 1'b0;
      bus.btnd <= 1'b0;
      done     <= 1'b0;
      if (w_load) begin
        {bus.btnl, bus.btnc, bus.btnr} <= w_rd[OP_LSB +: 3];
        bus.sw <= w_rd[OPND_LSB +: 16];
        r_exp  <= w_rd[EXP_LSB +: 16];
      end
      case (r_state)
        S_IDLE:
          if (start) begin
            r_len      <= w_len;
            r_idx      <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            busy       <= 1'b1;
            bus.btnu   <= 1'b1;
            r_state    <= S_RST;
          end
        S_RST: begin
          done    <= r_len == '0;
          r_state <= r_len == '0 ? S_DONE : S_SETUP;
        end
        S_SETUP: begin
          bus.btnd <= 1'b1;
          r_state  <= S_STROBE;
        end
        S_STROBE: begin
          r_cnt   <= 4'(SETTLE - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt   <= r_cnt - 1'b1;
          r_state <= r_cnt == '0 ? S_CHECK : S_WAIT;
        end
        S_CHECK: begin
          if (bus.led == r_exp) pass_cnt <= pass_cnt + 1'b1;
          else begin
            fail_cnt   <= fail_cnt + 1'b1;
            first_fail <= fail_cnt == '0 ? r_idx : first_fail;
          end
          r_idx   <= r_idx + 1'b1;
          done    <= ~w_more;
          r_state <= w_more ? S_SETUP : S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed runs of the calc script against a cycle-level behavioural model
module tb_calc_sequencer;
  import calc_sequencer_pkg::*;
  localparam int DEPTH = 16, AW = 4, SETTLE = 2, P = 3 + SETTLE;
  logic clk = 0, rst = 1, prog_we = 0, start = 0;
  logic [AW-1:0] prog_addr = '0;
  logic [34:0] prog_data = '0;
  logic [AW:0] prog_len = '0;
  logic busy, done;
  logic [AW:0] pass_cnt, fail_cnt;
  logic [AW-1:0] first_fail;
  logic [15:0] acc = '0;
  int total = 0, bad = 0, cyc, nu, nd;
  calc_sequencer_if bus();
  assign bus.led = acc;
  calc_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start), .bus(bus), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] calc_fn(logic [15:0] a, logic [2:0] op, logic [15:0] s);
    case (op)
      OP_AND: return a & s;
      OP_OR:  return a | s;
      OP_ADD: return a + s;
      OP_SUB: return a - s;
      OP_SLT: return {15'd0, $signed(a) < $signed(s)};
      OP_LSL: return a << s[3:0];
      OP_ASR: return $signed(a) >>> s[3:0];
      default: return a ^ s;
    endcase
  endfunction
  // stand-in for the calc accumulator on the other side of the bus
  always @(posedge clk)
    if (bus.btnu) acc <= '0;
    else if (bus.btnd) acc <= calc_fn(acc, {bus.btnl, bus.btnc, bus.btnr}, bus.sw);
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [34:0] script [9] = '{
    {OP_ADD, 16'h354a, 16'h354a}, {OP_SUB, 16'h1234, 16'h2316}, {OP_OR,  16'h1001, 16'h3317},
    {OP_AND, 16'hf0f0, 16'h3010}, {OP_XOR, 16'h1fa2, 16'h2fb2}, {OP_ADD, 16'h6aa2, 16'h9a54},
    {OP_LSL, 16'h0004, 16'ha540}, {OP_ASR, 16'h0001, 16'hd2a0}, {OP_SLT, 16'h46ff, 16'h0001}};
  // model: m_k is the cycle index since the accepted start (start cycle = 0)
  logic [34:0] m_prog [DEPTH];
  int m_k = -1, m_len = 0;
  int m_pass [DEPTH+1], m_fail [DEPTH+1], m_ff [DEPTH+1];
  logic m_busy;
  assign m_busy = m_k >= 1 && m_k <= 2 + m_len * P;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_k   <= -1;
      m_len <= 0;
    end else begin
      if (prog_we && !m_busy) m_prog[prog_addr] <= prog_data;
      if (start && !m_busy) begin
        m_k   <= 1;
        m_len <= prog_len > DEPTH ? DEPTH : int'(prog_len);
      end else if (m_k >= 1) m_k <= m_k + 1;
    end
  always @(negedge clk) begin
    int e, sc, eb;
    logic [15:0] a;
    if (!rst) begin
      if (m_k == 1) begin
        a = '0;
        for (int i = 0; i < m_len; i++) begin
          a = calc_fn(a, m_prog[i][34:32], m_prog[i][31:16]);
          m_pass[i+1] = m_pass[i] + int'(a == m_prog[i][15:0]);
          m_fail[i+1] = m_fail[i] + int'(a != m_prog[i][15:0]);
          m_ff[i+1]   = (m_fail[i] == 0 && a != m_prog[i][15:0]) ? i : m_ff[i];
        end
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_k == 2 + m_len * P);
      chk("btnu", bus.btnu, m_k == 1);
      eb = 0;
      if (m_k >= 2 && m_k < 2 + m_len * P) begin
        e  = (m_k - 2) / P;
        eb = int'((m_k - 2) % P == 1);
        chk("op", {bus.btnl, bus.btnc, bus.btnr}, m_prog[e][34:32]);
        chk("sw", bus.sw, m_prog[e][31:16]);
      end
      chk("btnd", bus.btnd, eb);
      sc = m_k < 2 ? 0 : ((m_k - 2) / P > m_len ? m_len : (m_k - 2) / P);
      chk("pass_cnt", pass_cnt, m_pass[sc]);
      chk("fail_cnt", fail_cnt, m_fail[sc]);
      if (m_fail[sc] != 0) chk("first_fail", first_fail, m_ff[sc]);
    end
  end
  task automatic wr(int ad, logic [34:0] d);
    prog_we = 1;
    prog_addr = ad[AW-1:0];
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask
  task automatic all_zero();
    chk("rz_busy", busy, 0); chk("rz_done", done, 0);
    chk("rz_pass", pass_cnt, 0); chk("rz_fail", fail_cnt, 0); chk("rz_ff", first_fail, 0);
    chk("rz_btnu", bus.btnu, 0); chk("rz_btnd", bus.btnd, 0);
    chk("rz_op", {bus.btnl, bus.btnc, bus.btnr}, 0); chk("rz_sw", bus.sw, 0);
  endtask
  // start a run; optionally write entry 0 on the start edge, poke start+write mid-run, or reset mid-run
  task automatic run(int len, bit wr0, int poke, int rst_at);
    start = 1;
    prog_len = len[AW:0];
    if (wr0) begin
      prog_we = 1; prog_addr = '0; prog_data = script[0];
    end
    @(posedge clk); #1;
    start = 0; prog_we = 0;
    cyc = 0; nu = 0; nd = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      nu += int'(bus.btnu);
      nd += int'(bus.btnd);
      if (done) break;
      if (cyc == rst_at) begin
        rst = 1;
        #1 all_zero();
        @(posedge clk); #1 rst = 0;
        return;
      end
      if (cyc == poke) begin
        start = 1; prog_we = 1; prog_addr = '0; prog_data = {OP_AND, 16'h0, 16'h0};
      end else if (cyc == poke + 1) begin
        start = 0; prog_we = 0;
      end
    end
    chk("done_seen", done, 1);
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 all_zero();
    rst = 0;
    wr(0, {OP_ADD, 16'h0, 16'hbeef});
    for (int i = 1; i < 9; i++) wr(i, script[i]);
    for (int i = 9; i < DEPTH; i++) wr(i, {OP_XOR, 16'h0, 16'h0001});
    run(9, 1, 0, 0);
    chk("t1_cyc", cyc, 47); chk("t1_pass", pass_cnt, 9); chk("t1_fail", fail_cnt, 0);
    chk("t1_btnu", nu, 1); chk("t1_btnd", nd, 9);
    wr(3, {script[3][34:16], 16'h3011});
    wr(6, {script[6][34:16], 16'ha541});
    run(9, 0, 0, 0);
    chk("t2_pass", pass_cnt, 7); chk("t2_fail", fail_cnt, 2); chk("t2_ff", first_fail, 3);
    wr(3, script[3]);
    wr(6, script[6]);
    run(0, 0, 0, 0);
    chk("t3_cyc", cyc, 2); chk("t3_btnu", nu, 1); chk("t3_btnd", nd, 0);
    chk("t3_pass", pass_cnt, 0); chk("t3_fail", fail_cnt, 0);
    run(20, 0, 0, 0);
    chk("t4_cyc", cyc, 82); chk("t4_pass", pass_cnt, 16); chk("t4_fail", fail_cnt, 0);
    run(9, 0, 10, 0);
    chk("t5_cyc", cyc, 47); chk("t5_pass", pass_cnt, 9); chk("t5_fail", fail_cnt, 0);
    run(9, 0, 0, 0);
    chk("t5_mem_pass", pass_cnt, 9);
    run(9, 0, 0, 24);
    run(9, 0, 0, 0);
    chk("t6_cyc", cyc, 47); chk("t6_pass", pass_cnt, 9); chk("t6_fail", fail_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
